instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised instruction decoder/sequencer for the systolic-array controller. Accepts 64-bit instructions over a valid/ready handshake and decodes them into registered, single-cycle buffer and accumulator command strobes. Expands burst opcodes (MAC, SEND_WT) into consecutive read beats with an auto-incrementing address. Sits between the host instruction stream and the input, weight and output buffers and the accumulator.

## Interface
- INSTR_W, 64, instruction width
- ADDR_W, 16, buffer address width
- DATA_W, 32, write-data width
- LEN_W, 8, burst length field width
- OBUF_ADDR_W, 4, output-buffer address width
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction this cycle
- instr  in  INSTR_W  instruction word
- inp_buf_re / inp_buf_we  out  1  input-buffer read / write strobe
- inp_buf_addr  out  ADDR_W  input-buffer address
- inp_buf_wdata  out  DATA_W  input-buffer write data
- wt_buf_re / wt_buf_we  out  1  weight-buffer read / write strobe
- wt_buf_addr  out  ADDR_W  weight-buffer address
- wt_buf_wdata  out  DATA_W  weight-buffer write data
- acc_to_obuf  out  1  accumulator result to output buffer
- obuf_send  out  1  output buffer transmits entry
- obuf_addr  out  OBUF_ADDR_W  output-buffer address
- acc_copy  out  1  accumulator copies data to output buffer
- busy  out  1  burst in progress
- err_opcode  out  1  one-cycle pulse on an undefined opcode

## Operation
- Fields, MSB first: opcode[5], addr[ADDR_W], len[LEN_W], data[DATA_W]. The remaining LSBs are ignored.
- Handshake: an instruction is accepted on a rising edge where instr_valid && instr_ready. instr is sampled only at that edge.
- Opcodes and the outputs they drive:
  - 0x00: none. Accepted, no output.
  - 0x1F: NOP. Accepted, no output.
  - 0x01 MAC: burst. Drives inp_buf_re and inp_buf_addr.
  - 0x02 SEND_WT: burst. Drives wt_buf_re and wt_buf_addr.
  - 0x03 STORE_OUT: drives acc_to_obuf, with obuf_addr = addr[OBUF_ADDR_W-1:0].
  - 0x04 RECV_IN: drives inp_buf_we, inp_buf_addr and inp_buf_wdata.
  - 0x05 RECV_WT: drives wt_buf_we, wt_buf_addr and wt_buf_wdata.
  - 0x06 TX_OUT: drives obuf_send, with obuf_addr = addr[OBUF_ADDR_W-1:0].
  - 0x07 ACC_COPY: drives acc_copy.
  - Any other opcode: drives err_opcode only.
- len is used by burst opcodes only; a burst issues len+1 beats. For all other opcodes len is ignored.
- Strobes are one-cycle pulses. When their strobe is low, address and data outputs are 0.
- Burst beats use addresses addr, addr+1, …, addr+len, computed modulo 2^ADDR_W, so they wrap from all-ones to 0.
- State machine:
  - IDLE, accepting a burst with len>0: issue beat 0, load rem=len and next address addr+1, go to BURST.
  - IDLE, accepting any other instruction: issue its outputs and stay in IDLE.
  - BURST: issue one beat per cycle and decrement rem. The edge that issues the final beat (rem 1→0) returns to IDLE.
- busy = (state==BURST).

## Timing
- Every output is registered and is visible in the cycle after the edge that produced it.
- Single-beat instructions: latency 1. Full throughput, one per cycle with instr_ready held at 1.
- instr_ready is registered, with next value (next_state==IDLE).
- For a burst with len=L accepted at edge E0:
  - beats are visible in the cycles after E0..EL;
  - instr_ready is 0 in the cycles after E0..E(L-1);
  - the next instruction is accepted at E(L+1) with no bubble between beats.
- Reset (asynchronous): state=IDLE, rem=0, and all strobes, addresses, data, busy, err_opcode and instr_ready are 0. instr_ready rises on the first edge after rst_n deasserts.
- Reset during a burst aborts it; no further beats are issued.
- instr_valid held high while instr_ready=0 has no effect, and instr may change freely during that time.

## Structure
- The shared package controller_pkg holds:
  - opcode localparams;
  - field offset functions derived from the parameters;
  - the state enum {IDLE, BURST}.
- No sub-module is needed: one decode and issue process plus the burst counter and address register.

## Test plan
- Reset, then RECV_IN addr=0x0012 data=0xDEADBEEF → one cycle later inp_buf_we=1, inp_buf_addr=0x0012, inp_buf_wdata=0xDEADBEEF, all 0 the following cycle.
- MAC addr=0x0100 len=3 → inp_buf_re high for 4 consecutive cycles with addresses 0x0100..0x0103. instr_ready is 0 for 3 cycles, and a queued TX_OUT issues obuf_send in the cycle right after beat 3.
- SEND_WT addr=0xFFFE len=2 → wt_buf_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- Back-to-back STORE_OUT addr=0x5, ACC_COPY, opcode 0x0A, NOP → acc_to_obuf with obuf_addr=5, then acc_copy, then err_opcode, then no outputs, one per cycle.
- rst_n pulsed low during beat 2 of MAC len=7 → all outputs 0 immediately, no further beats, instr_ready=1 one edge after release.
- MAC len=0 → a single beat, busy never asserts, instr_ready stays 1.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared controller definitions for the instruction sequencer.
// Holds the opcode encodings, the instruction field offset helpers and the
// sequencer state enum. Instruction fields, MSB first:
// opcode[5], addr[ADDR_W], len[LEN_W], data[DATA_W]; remaining LSBs unused.
package controller_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NONE      = 5'h00;
    localparam logic [OPC_W-1:0] OP_MAC       = 5'h01;
    localparam logic [OPC_W-1:0] OP_SEND_WT   = 5'h02;
    localparam logic [OPC_W-1:0] OP_STORE_OUT = 5'h03;
    localparam logic [OPC_W-1:0] OP_RECV_IN   = 5'h04;
    localparam logic [OPC_W-1:0] OP_RECV_WT   = 5'h05;
    localparam logic [OPC_W-1:0] OP_TX_OUT    = 5'h06;
    localparam logic [OPC_W-1:0] OP_ACC_COPY  = 5'h07;
    localparam logic [OPC_W-1:0] OP_NOP       = 5'h1F;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_e;

    // LSB position of each field within the instruction word
    function automatic int unsigned opc_lsb(input int unsigned instr_w);
        return instr_w - OPC_W;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned instr_w,
                                             input int unsigned addr_w);
        return opc_lsb(instr_w) - addr_w;
    endfunction

    function automatic int unsigned len_lsb(input int unsigned instr_w,
                                            input int unsigned addr_w,
                                            input int unsigned len_w);
        return addr_lsb(instr_w, addr_w) - len_w;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned instr_w,
                                             input int unsigned addr_w,
                                             input int unsigned len_w,
                                             input int unsigned data_w);
        return len_lsb(instr_w, addr_w, len_w) - data_w;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction stream handshake between host and sequencer.
//   instr_valid : host presents an instruction
//   instr_ready : sequencer accepts on this edge if valid is also high
//   instr       : instruction word
// master = instruction source (host), slave = sequencer.
interface instr_sequencer_if #(
    parameter int unsigned INSTR_W = 64
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction decoder/sequencer for the systolic-array controller.
// Decodes 64-bit instructions into registered single-cycle buffer and
// accumulator strobes; MAC / SEND_WT expand into len+1 read beats with an
// auto-incrementing (wrapping) address.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_if (slave)       : instr_valid / instr_ready / instr handshake
//   inp_buf_*           : input-buffer read/write strobes, address, data
//   wt_buf_*            : weight-buffer read/write strobes, address, data
//   acc_to_obuf, obuf_send, obuf_addr, acc_copy : accumulator/output buffer
//   busy                : burst in progress
//   err_opcode          : one-cycle pulse on an undefined opcode
module instr_sequencer
    import controller_pkg::*;
#(
    parameter int unsigned INSTR_W     = 64,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned OBUF_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_sequencer_if.slave       in_if,
    output logic                   inp_buf_re,
    output logic                   inp_buf_we,
    output logic [ADDR_W-1:0]      inp_buf_addr,
    output logic [DATA_W-1:0]      inp_buf_wdata,
    output logic                   wt_buf_re,
    output logic                   wt_buf_we,
    output logic [ADDR_W-1:0]      wt_buf_addr,
    output logic [DATA_W-1:0]      wt_buf_wdata,
    output logic                   acc_to_obuf,
    output logic                   obuf_send,
    output logic [OBUF_ADDR_W-1:0] obuf_addr,
    output logic                   acc_copy,
    output logic                   busy,
    output logic                   err_opcode
);

    localparam int unsigned OPC_LSB  = opc_lsb(INSTR_W);
    localparam int unsigned ADDR_LSB = addr_lsb(INSTR_W, ADDR_W);
    localparam int unsigned LEN_LSB  = len_lsb(INSTR_W, ADDR_W, LEN_W);
    localparam int unsigned DATA_LSB = data_lsb(INSTR_W, ADDR_W, LEN_W, DATA_W);

    // Field extraction
    logic [OPC_W-1:0]  f_opc;
    logic [ADDR_W-1:0] f_addr;
    logic [LEN_W-1:0]  f_len;
    logic [DATA_W-1:0] f_data;
    logic              unused_lsbs;

    assign f_opc       = in_if.instr[OPC_LSB  +: OPC_W];
    assign f_addr      = in_if.instr[ADDR_LSB +: ADDR_W];
    assign f_len       = in_if.instr[LEN_LSB  +: LEN_W];
    assign f_data      = in_if.instr[DATA_LSB +: DATA_W];
    assign unused_lsbs = ^in_if.instr[DATA_LSB-1:0];

    // State
    seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              burst_wt_q, burst_wt_d;  // 1: SEND_WT burst, 0: MAC
    logic              ready_q;

    // Next output values
    logic                   inp_re_d, inp_we_d, wt_re_d, wt_we_d;
    logic [ADDR_W-1:0]      inp_addr_d, wt_addr_d;
    logic [DATA_W-1:0]      inp_wdata_d, wt_wdata_d;
    logic                   acc_to_obuf_d, obuf_send_d, acc_copy_d, err_d;
    logic [OBUF_ADDR_W-1:0] obuf_addr_d;

    logic accept;
    assign accept = in_if.instr_valid && ready_q;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        next_addr_d   = next_addr_q;
        burst_wt_d    = burst_wt_q;
        inp_re_d      = 1'b0;
        inp_we_d      = 1'b0;
        inp_addr_d    = '0;
        inp_wdata_d   = '0;
        wt_re_d       = 1'b0;
        wt_we_d       = 1'b0;
        wt_addr_d     = '0;
        wt_wdata_d    = '0;
        acc_to_obuf_d = 1'b0;
        obuf_send_d   = 1'b0;
        obuf_addr_d   = '0;
        acc_copy_d    = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (f_opc)
                        OP_NONE, OP_NOP: ;
                        OP_MAC, OP_SEND_WT: begin
                            // Beat 0 is issued straight from the instruction;
                            // the counter only tracks the remaining beats.
                            if (f_opc == OP_SEND_WT) begin
                                wt_re_d   = 1'b1;
                                wt_addr_d = f_addr;
                            end else begin
                                inp_re_d   = 1'b1;
                                inp_addr_d = f_addr;
                            end
                            if (f_len != '0) begin
                                state_d     = BURST;
                                rem_d       = f_len;
                                next_addr_d = f_addr + ADDR_W'(1);
                                burst_wt_d  = (f_opc == OP_SEND_WT);
                            end
                        end
                        OP_STORE_OUT: begin
                            acc_to_obuf_d = 1'b1;
                            obuf_addr_d   = f_addr[OBUF_ADDR_W-1:0];
                        end
                        OP_RECV_IN: begin
                            inp_we_d    = 1'b1;
                            inp_addr_d  = f_addr;
                            inp_wdata_d = f_data;
                        end
                        OP_RECV_WT: begin
                            wt_we_d    = 1'b1;
                            wt_addr_d  = f_addr;
                            wt_wdata_d = f_data;
                        end
                        OP_TX_OUT: begin
                            obuf_send_d = 1'b1;
                            obuf_addr_d = f_addr[OBUF_ADDR_W-1:0];
                        end
                        OP_ACC_COPY: acc_copy_d = 1'b1;
                        default:     err_d      = 1'b1;
                    endcase
                end
            end
            BURST: begin
                if (burst_wt_q) begin
                    wt_re_d   = 1'b1;
                    wt_addr_d = next_addr_q;
                end else begin
                    inp_re_d   = 1'b1;
                    inp_addr_d = next_addr_q;
                end
                next_addr_d = next_addr_q + ADDR_W'(1);
                rem_d       = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            next_addr_q   <= '0;
            burst_wt_q    <= 1'b0;
            ready_q       <= 1'b0;
            inp_buf_re    <= 1'b0;
            inp_buf_we    <= 1'b0;
            inp_buf_addr  <= '0;
            inp_buf_wdata <= '0;
            wt_buf_re     <= 1'b0;
            wt_buf_we     <= 1'b0;
            wt_buf_addr   <= '0;
            wt_buf_wdata  <= '0;
            acc_to_obuf   <= 1'b0;
            obuf_send     <= 1'b0;
            obuf_addr     <= '0;
            acc_copy      <= 1'b0;
            err_opcode    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            next_addr_q   <= next_addr_d;
            burst_wt_q    <= burst_wt_d;
            ready_q       <= (state_d == IDLE);
            inp_buf_re    <= inp_re_d;
            inp_buf_we    <= inp_we_d;
            inp_buf_addr  <= inp_addr_d;
            inp_buf_wdata <= inp_wdata_d;
            wt_buf_re     <= wt_re_d;
            wt_buf_we     <= wt_we_d;
            wt_buf_addr   <= wt_addr_d;
            wt_buf_wdata  <= wt_wdata_d;
            acc_to_obuf   <= acc_to_obuf_d;
            obuf_send     <= obuf_send_d;
            obuf_addr     <= obuf_addr_d;
            acc_copy      <= acc_copy_d;
            err_opcode    <= err_d;
        end
    end

    assign in_if.instr_ready = ready_q;
    assign busy              = (state_q == BURST);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: reset, single-beat decode, bursts
// with address wrap, back-to-back issue, reset abort and zero-length burst.
module tb_instr_sequencer;
    import controller_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if #(.INSTR_W(64)) seq_if ();

    logic        inp_buf_re, inp_buf_we, wt_buf_re, wt_buf_we;
    logic [15:0] inp_buf_addr, wt_buf_addr;
    logic [31:0] inp_buf_wdata, wt_buf_wdata;
    logic        acc_to_obuf, obuf_send, acc_copy, busy, err_opcode;
    logic [3:0]  obuf_addr;

    instr_sequencer #(
        .INSTR_W(64), .ADDR_W(16), .DATA_W(32), .LEN_W(8), .OBUF_ADDR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_if(seq_if.slave),
        .inp_buf_re(inp_buf_re), .inp_buf_we(inp_buf_we),
        .inp_buf_addr(inp_buf_addr), .inp_buf_wdata(inp_buf_wdata),
        .wt_buf_re(wt_buf_re), .wt_buf_we(wt_buf_we),
        .wt_buf_addr(wt_buf_addr), .wt_buf_wdata(wt_buf_wdata),
        .acc_to_obuf(acc_to_obuf), .obuf_send(obuf_send),
        .obuf_addr(obuf_addr), .acc_copy(acc_copy),
        .busy(busy), .err_opcode(err_opcode)
    );

    // All outputs packed; LSB is instr_ready so "idle and ready" == 1.
    logic [109:0] all_outs;
    assign all_outs = {inp_buf_re, inp_buf_we, inp_buf_addr, inp_buf_wdata,
                       wt_buf_re, wt_buf_we, wt_buf_addr, wt_buf_wdata,
                       acc_to_obuf, obuf_send, obuf_addr, acc_copy,
                       busy, err_opcode, seq_if.instr_ready};

    localparam logic [109:0] ALL_ZERO   = '0;
    localparam logic [109:0] IDLE_READY = 110'd1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [15:0] addr,
                                       input logic [7:0] len, input logic [31:0] data);
        return {op, addr, len, data, 3'b000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w);
        seq_if.instr       = w;
        seq_if.instr_valid = 1'b1;
    endtask

    task automatic idle_in();
        seq_if.instr_valid = 1'b0;
        seq_if.instr       = '0;
    endtask

    task automatic chk_inp_re(input string tag, input logic [15:0] a, input logic rdy,
                              input logic bsy);
        check_eq({tag, "_re"},   inp_buf_re, 1'b1);
        check_eq({tag, "_addr"}, inp_buf_addr, a);
        check_eq({tag, "_rdy"},  seq_if.instr_ready, rdy);
        check_eq({tag, "_busy"}, busy, bsy);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        step();
        check_eq("reset_outs", all_outs, ALL_ZERO);
        step();
        rst_n = 1'b1;
        step();
        check_eq("ready_after_reset", all_outs, IDLE_READY);

        // RECV_IN single beat
        send(mk(OP_RECV_IN, 16'h0012, 8'h00, 32'hDEADBEEF));
        step();
        idle_in();
        check_eq("recv_in_we",    inp_buf_we, 1'b1);
        check_eq("recv_in_addr",  inp_buf_addr, 16'h0012);
        check_eq("recv_in_wdata", inp_buf_wdata, 32'hDEADBEEF);
        check_eq("recv_in_rdy",   seq_if.instr_ready, 1'b1);
        step();
        check_eq("recv_in_clear", all_outs, IDLE_READY);

        // MAC len=3 with a queued TX_OUT
        send(mk(OP_MAC, 16'h0100, 8'd3, 32'h0));
        step();
        chk_inp_re("mac_b0", 16'h0100, 1'b0, 1'b1);
        send(mk(OP_TX_OUT, 16'h0009, 8'h00, 32'h0));
        step();
        chk_inp_re("mac_b1", 16'h0101, 1'b0, 1'b1);
        step();
        chk_inp_re("mac_b2", 16'h0102, 1'b0, 1'b1);
        step();
        chk_inp_re("mac_b3", 16'h0103, 1'b1, 1'b0);
        step();
        idle_in();
        check_eq("txout_send", obuf_send, 1'b1);
        check_eq("txout_addr", obuf_addr, 4'h9);
        check_eq("txout_no_re", inp_buf_re, 1'b0);
        step();
        check_eq("txout_clear", all_outs, IDLE_READY);

        // SEND_WT wrapping burst
        send(mk(OP_SEND_WT, 16'hFFFE, 8'd2, 32'h0));
        step();
        idle_in();
        check_eq("wt_b0_re",   wt_buf_re, 1'b1);
        check_eq("wt_b0_addr", wt_buf_addr, 16'hFFFE);
        check_eq("wt_b0_inp",  inp_buf_re, 1'b0);
        step();
        check_eq("wt_b1_re",   wt_buf_re, 1'b1);
        check_eq("wt_b1_addr", wt_buf_addr, 16'hFFFF);
        step();
        check_eq("wt_b2_re",   wt_buf_re, 1'b1);
        check_eq("wt_b2_addr", wt_buf_addr, 16'h0000);
        check_eq("wt_b2_rdy",  seq_if.instr_ready, 1'b1);
        step();
        check_eq("wt_clear", all_outs, IDLE_READY);

        // Back-to-back single-beat ops
        send(mk(OP_STORE_OUT, 16'h0005, 8'hFF, 32'h0));
        step();
        check_eq("store_strobe", acc_to_obuf, 1'b1);
        check_eq("store_addr",   obuf_addr, 4'h5);
        send(mk(OP_ACC_COPY, 16'h0000, 8'h00, 32'h0));
        step();
        check_eq("acc_copy", all_outs, {106'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        send(mk(5'h0A, 16'h1234, 8'h00, 32'h0));
        step();
        check_eq("err_opcode", all_outs, {107'd0, 1'b0, 1'b1, 1'b1});
        send(mk(OP_NOP, 16'h1234, 8'h05, 32'h55));
        step();
        idle_in();
        check_eq("nop_quiet", all_outs, IDLE_READY);

        // Reset during MAC len=7
        send(mk(OP_MAC, 16'h0200, 8'd7, 32'h0));
        step();
        idle_in();
        chk_inp_re("rst_b0", 16'h0200, 1'b0, 1'b1);
        step();
        chk_inp_re("rst_b1", 16'h0201, 1'b0, 1'b1);
        step();
        chk_inp_re("rst_b2", 16'h0202, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_abort_now", all_outs, ALL_ZERO);
        step();
        check_eq("rst_abort_held", all_outs, ALL_ZERO);
        rst_n = 1'b1;
        step();
        check_eq("rst_release_ready", all_outs, IDLE_READY);
        step();
        check_eq("rst_no_beats", all_outs, IDLE_READY);

        // MAC len=0: single beat, never busy
        send(mk(OP_MAC, 16'h0300, 8'd0, 32'h0));
        step();
        idle_in();
        chk_inp_re("mac0", 16'h0300, 1'b1, 1'b0);
        step();
        check_eq("mac0_clear", all_outs, IDLE_READY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
